mem_input_loader: RTL and testbench
===================================

Name: mem_input_loader

Overview:
Producer-side writer for the processing-chain input memories. It accepts a valid/ready word stream and writes it through a BRAM write port, filling one of two pages per bunch crossing (BX). When a page is committed, it raises a one-cycle start to the first process and presents that page's BX and word count. It holds off the stream while both pages are still owned by the consumer.

Parameters:
DATA_WIDTH, 32, memory word width
PAGE_DEPTH, 32, words per page (power of 2)
ADDR_WIDTH, 6, write address width = log2(PAGE_DEPTH)+1; MSB selects the page

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  DATA_WIDTH  stream word
s_last  in  1  marks the final word of the event
bx_in  in  2  BX tag; sampled with the first word of an event
mem_ena  out  1  BRAM port-A enable
mem_wea  out  1  BRAM port-A write enable
mem_writeaddr  out  ADDR_WIDTH  {page, word index}
mem_din  out  DATA_WIDTH  write data
start_out  out  1  one-cycle start pulse to the consumer process
bx_out  out  2  BX of the committed page; held until the next commit
nwords_out  out  ADDR_WIDTH  words stored in the committed page; held until the next commit
page_out  out  1  page index of the committed page
done_in  in  1  consumer done pulse; frees the oldest busy page
overflow  out  1  sticky: an event exceeded PAGE_DEPTH
bx_err  out  1  sticky BX sequence error (optional feature only)

Behaviour:
- Reset (asynchronous): every output is 0, wr_page=0, both busy flags=0, FSM=IDLE. A partially loaded event is discarded.
- Word transfer: a word is accepted when s_valid && s_ready.
- Write path: registered. One cycle after an accepted word: mem_ena=mem_wea=1, mem_writeaddr={wr_page, idx}, mem_din=the accepted word. Otherwise mem_ena=mem_wea=0.
- FSM states:
  - IDLE: s_ready = !busy[wr_page]. On the first accepted word: latch bx_in, idx=0, go to LOAD (or COMMIT if s_last is set).
  - LOAD: s_ready=1. Each accepted word increments idx. Once idx reaches PAGE_DEPTH, further words are accepted but not written, and overflow is set. An accepted word with s_last goes to COMMIT.
  - COMMIT (one cycle, aligned with the write of the last word; s_ready=0):
    - start_out=1;
    - bx_out = latched BX;
    - nwords_out = min(count, PAGE_DEPTH);
    - page_out = wr_page;
    - busy[wr_page] set, wr_page toggles;
    - go to IDLE.
  - In IDLE, s_ready stays 0 while the new wr_page is busy (the WAIT_FREE condition).
- Minimum event: one word (s_last on the first word), giving nwords_out=1.
- Page accounting:
  - done_in clears the busy flag of the older committed page, tracked in FIFO order by a read-page pointer.
  - done_in with no page busy is ignored.
  - Commit and done_in in the same cycle are both applied.
- Throughput: one word per cycle within an event; one idle cycle (COMMIT) between events.
- Address wrap: idx saturates at PAGE_DEPTH-1 for writing; it never wraps into the other page.

Optional Feature:
LOADER_BXCHECK_EN
- Defined: at each commit, if a previous commit exists and the latched BX != previous bx_out+1 (mod 4), bx_err is set. bx_err is sticky until reset.
- Undefined: bx_err is tied to 0 and there is no BX-history logic.

Decomposition:
- Package loader_pkg: DATA_WIDTH/PAGE_DEPTH/ADDR_WIDTH defaults, the FSM state enum (IDLE, LOAD, COMMIT), and the BX width constant (2).
- Sub-module page_tracker: two busy flags plus the write and read page pointers. Inputs commit and done_in; outputs busy_wr and wr_page.

Test Plan:
1. Reset, then a 5-word event with bx_in=1 and data 0x10..0x14 → writes to addresses 0..4. start_out pulses once; bx_out=1, nwords_out=5, page_out=0.
2. A second event (bx=2, 3 words) with no done_in → writes to addresses 32..34 with page_out=1. A third event is then stalled (s_ready=0) until a done_in pulse, after which it writes to page 0.
3. A 40-word event → only addresses 0..31 are written, nwords_out=32, overflow=1 and stays 1.
4. A single-word event with s_last on the first word → one write, start_out pulse, nwords_out=1.
5. Assert reset mid-LOAD after 3 words → all outputs 0 immediately, no start_out; the next event starts at page 0, address 0.
6. With LOADER_BXCHECK_EN, BX sequence 0,1,3 → bx_err asserts at the third commit. Without the macro, bx_err stays 0.

Source files
------------

// File: rtl/mem_input_loader_pkg.sv
// +-----------------------------------------------------------------+
// | loader_pkg: shared sizes, BX width and FSM states for the loader |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package loader_pkg;
  localparam int LDR_DATA_WIDTH = 32;
  localparam int LDR_PAGE_DEPTH = 32;
  localparam int LDR_ADDR_WIDTH = 6;
  localparam int BX_WIDTH       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/mem_input_loader_page_tracker.sv
// +-----------------------------------------------------------------+
// | page_tracker: ping-pong page ownership, freed in commit order    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module page_tracker (
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic done_in,
  output logic busy_wr,
  output logic wr_page
);
  logic [1:0] busy;
  logic [1:0] busy_nxt;
  logic       rd_page;
  logic       release_pg;

  // done_in with the oldest page already free means nothing is busy
  assign release_pg = done_in && busy[rd_page];

  always_comb begin
    busy_nxt = busy;
    if (release_pg) busy_nxt[rd_page] = 1'b0;
    if (commit)     busy_nxt[wr_page] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 2'b00;
      wr_page <= 1'b0;
      rd_page <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (commit)     wr_page <= ~wr_page;
      if (release_pg) rd_page <= ~rd_page;
    end
  end

  assign busy_wr = busy[wr_page];
endmodule

`default_nettype wire

// File: rtl/mem_input_loader.sv
// +-----------------------------------------------------------------+
// | mem_input_loader: stream-to-BRAM page writer with commit start   |
// | Optional macro LOADER_BXCHECK_EN enables sticky bx_err. Rev 1.0  |
// +-----------------------------------------------------------------+
`default_nettype none

module mem_input_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = LDR_DATA_WIDTH,
  parameter int PAGE_DEPTH = LDR_PAGE_DEPTH,
  parameter int ADDR_WIDTH = LDR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic [BX_WIDTH-1:0]   bx_in,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_writeaddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  start_out,
  output logic [BX_WIDTH-1:0]   bx_out,
  output logic [ADDR_WIDTH-1:0] nwords_out,
  output logic                  page_out,
  input  logic                  done_in,
  output logic                  overflow,
  output logic                  bx_err
);
  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(PAGE_DEPTH);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [ADDR_WIDTH-1:0] count_nxt;
  logic [BX_WIDTH-1:0]   bx_lat;
  logic [BX_WIDTH-1:0]   bx_evt;
  logic                  busy_wr;
  logic                  wr_page;
  logic                  commit;
  logic                  accept;
  logic                  room;

  page_tracker u_tracker (
    .clk     (clk),
    .reset   (reset),
    .commit  (commit),
    .done_in (done_in),
    .busy_wr (busy_wr),
    .wr_page (wr_page)
  );

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        s_ready = !busy_wr;
        if (s_valid && !busy_wr) state_nxt = s_last ? COMMIT : LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // count holds words stored so far and saturates at PAGE_DEPTH
  assign accept    = s_valid && s_ready;
  assign cur_idx   = (state == IDLE) ? '0 : count;
  assign room      = cur_idx < FULL;
  assign count_nxt = room ? cur_idx + ADDR_WIDTH'(1) : cur_idx;
  assign bx_evt    = (state == IDLE) ? bx_in : bx_lat;

  // Commit outputs register with the last word so they line up with COMMIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      bx_lat        <= '0;
      mem_ena       <= 1'b0;
      mem_wea       <= 1'b0;
      mem_writeaddr <= '0;
      mem_din       <= '0;
      start_out     <= 1'b0;
      bx_out        <= '0;
      nwords_out    <= '0;
      page_out      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_ena   <= 1'b0;
      mem_wea   <= 1'b0;
      start_out <= 1'b0;
      if (accept) begin
        count <= count_nxt;
        if (state == IDLE) bx_lat <= bx_in;
        if (room) begin
          mem_ena       <= 1'b1;
          mem_wea       <= 1'b1;
          mem_writeaddr <= {wr_page, cur_idx[IDX_W-1:0]};
          mem_din       <= s_data;
        end else begin
          overflow <= 1'b1;
        end
        if (s_last) begin
          start_out  <= 1'b1;
          bx_out     <= bx_evt;
          nwords_out <= count_nxt;
          page_out   <= wr_page;
        end
      end
    end
  end

`ifdef LOADER_BXCHECK_EN
  logic have_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_prev <= 1'b0;
      bx_err    <= 1'b0;
    end else if (accept && s_last) begin
      have_prev <= 1'b1;
      if (have_prev && (bx_evt != bx_out + BX_WIDTH'(1))) bx_err <= 1'b1;
    end
  end
`else
  assign bx_err = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_mem_input_loader.sv
// Directed table-driven bench for mem_input_loader: writes, commits, stall, overflow, reset, BX check.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_input_loader;
  localparam int DW = 32;
  localparam int PD = 32;
  localparam int AW = 6;
`ifdef LOADER_BXCHECK_EN
  localparam logic EXP_BXERR = 1'b1;
`else
  localparam logic EXP_BXERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [1:0]    bx_in = '0;
  logic          mem_ena, mem_wea;
  logic [AW-1:0] mem_writeaddr;
  logic [DW-1:0] mem_din;
  logic          start_out;
  logic [1:0]    bx_out;
  logic [AW-1:0] nwords_out;
  logic          page_out;
  logic          done_in = 1'b0;
  logic          overflow;
  logic          bx_err;

  int n_checks = 0;
  int n_fail   = 0;
  int starts   = 0;
  logic [AW+DW-1:0] wr_q[$];

  typedef struct {
    logic [1:0]  bx;
    int          n;
    logic [31:0] d0;
    int          pre_done;
    logic        page;
    int          exp_nw;
  } ev_t;
  ev_t tbl[4];

  mem_input_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .bx_in(bx_in), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_writeaddr(mem_writeaddr), .mem_din(mem_din), .start_out(start_out),
    .bx_out(bx_out), .nwords_out(nwords_out), .page_out(page_out), .done_in(done_in),
    .overflow(overflow), .bx_err(bx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_ena && mem_wea) wr_q.push_back({mem_writeaddr, mem_din});
    if (start_out) starts++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] bx);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = last; bx_in = bx;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!s_ready) check("s_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic run_event(input ev_t e, input string name);
    int base = wr_q.size();
    int sb   = starts;
    int nexp = (e.n < PD) ? e.n : PD;
    for (int i = 0; i < e.n; i++) send_word(e.d0 + 32'(i), (i == e.n - 1), e.bx);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_nwrites"}, 64'(wr_q.size() - base), 64'(nexp));
    for (int i = 0; i < nexp && (base + i) < wr_q.size(); i++)
      check({name, "_write"}, 64'(wr_q[base + i]),
            64'({AW'(e.page * PD + i), e.d0 + 32'(i)}));
    check({name, "_starts"}, 64'(starts - sb), 64'd1);
    check({name, "_bx_out"}, 64'(bx_out), 64'(e.bx));
    check({name, "_nwords"}, 64'(nwords_out), 64'(e.exp_nw));
    check({name, "_page"}, 64'(page_out), 64'(e.page));
  endtask

  function automatic ev_t mk(input logic [1:0] bx, input int n, input logic [31:0] d0,
                             input int pre_done, input logic page, input int nw);
    ev_t e;
    e.bx = bx; e.n = n; e.d0 = d0; e.pre_done = pre_done; e.page = page; e.exp_nw = nw;
    return e;
  endfunction

  initial begin
    int base;
    int sb;
    tbl[0] = mk(2'd1, 5,  32'h10,  0, 1'b0, 5);
    tbl[1] = mk(2'd2, 3,  32'h20,  0, 1'b1, 3);
    tbl[2] = mk(2'd0, 40, 32'h100, 0, 1'b0, 32);
    tbl[3] = mk(2'd1, 1,  32'h200, 0, 1'b1, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({mem_ena, mem_wea, mem_writeaddr, mem_din, start_out, bx_out, nwords_out,
               page_out, overflow, bx_err}), 64'd0);
    reset = 1'b0;

    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < tbl[k].pre_done; j++) pulse_done();
      run_event(tbl[k], $sformatf("ev%0d", k));
    end

    // Both pages owned by the consumer: the third event must stall
    base = wr_q.size();
    s_valid = 1'b1; s_data = 32'h30; bx_in = 2'd3; s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", 64'(s_ready), 64'd0);
    end
    check("stall_no_write", 64'(wr_q.size() - base), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    pulse_done();
    run_event(mk(2'd3, 2, 32'h30, 0, 1'b0, 2), "ev_after_done");

    do_reset();
    for (int k = 2; k < 4; k++) begin
      for (int j = 0; j < tbl[k].pre_done; j++) pulse_done();
      run_event(tbl[k], $sformatf("ev%0d", k));
      check("overflow_sticky", 64'(overflow), 64'd1);
    end

    // Reset in the middle of an event discards it
    pulse_done();
    pulse_done();
    sb = starts;
    for (int i = 0; i < 3; i++) send_word(32'h300 + 32'(i), 1'b0, 2'd2);
    reset = 1'b1;
    #1;
    check("midload_reset_outputs",
          64'({mem_ena, mem_wea, mem_writeaddr, mem_din, start_out, bx_out, nwords_out,
               page_out, overflow, bx_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midload_no_start", 64'(starts - sb), 64'd0);
    run_event(mk(2'd0, 2, 32'h400, 0, 1'b0, 2), "ev_post_reset");

    // BX sequence 0,1,3
    do_reset();
    run_event(mk(2'd0, 1, 32'h500, 0, 1'b0, 1), "bx0");
    run_event(mk(2'd1, 1, 32'h510, 0, 1'b1, 1), "bx1");
    check("bx_err_clean", 64'(bx_err), 64'd0);
    pulse_done();
    run_event(mk(2'd3, 1, 32'h520, 0, 1'b0, 1), "bx3");
    check("bx_err_seq", 64'(bx_err), 64'(EXP_BXERR));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
